// File: rtl/seven_seg_scan_if.sv
// ---------------------------------------------------------------------------
// seven_seg_scan_if
// Bundles the data/control inputs and the display outputs of seven_seg_scan.
//   master : drives load/dataIn/blankMask/dpIn/lzbEn, observes the display
//   slave  : the scanner itself
// Ports carried:
//   load       capture strobe for dataIn/blankMask/dpIn
//   dataIn     4*NUM_DIGITS hex nibbles, digit 0 in the low nibble
//   blankMask  1 = force digit dark
//   dpIn       1 = light decimal point of that digit
//   lzbEn      leading-zero blanking enable (live, not latched)
//   sevenSegs  active-low segments, bit6 = g .. bit0 = a
//   dp         active-low decimal point
//   anodes     one-hot digit enable
//   digitIdx   index of the digit currently scanned
// ---------------------------------------------------------------------------
interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic                    load;
    logic [4*NUM_DIGITS-1:0] dataIn;
    logic [NUM_DIGITS-1:0]   blankMask;
    logic [NUM_DIGITS-1:0]   dpIn;
    logic                    lzbEn;
    logic [6:0]              sevenSegs;
    logic                    dp;
    logic [NUM_DIGITS-1:0]   anodes;
    logic [IDX_W-1:0]        digitIdx;

    modport master (
        output load, dataIn, blankMask, dpIn, lzbEn,
        input  sevenSegs, dp, anodes, digitIdx
    );

    modport slave (
        input  load, dataIn, blankMask, dpIn, lzbEn,
        output sevenSegs, dp, anodes, digitIdx
    );
endinterface

// File: rtl/seven_seg_scan.sv
// ---------------------------------------------------------------------------
// seven_seg_scan
// Time-multiplexed driver for a NUM_DIGITS hex seven-segment display.
// A prescaler divides clk by REFRESH_DIV; each wrap advances the scanned
// digit. The display works only from shadow registers captured on load.
// Segment, decimal-point and anode outputs are registered and so trail the
// scan state by one cycle. Anodes are held inactive for the first output
// cycle of every slot so the previous digit's glyph never ghosts onto the
// next digit while the segment lines settle.
// Ports:
//   clk    single clock, rising edge
//   reset  synchronous, active-high
//   sif    seven_seg_scan_if.slave (load/data inputs, display outputs)
// ---------------------------------------------------------------------------
module seven_seg_scan #(
    parameter int NUM_DIGITS    = 4,
    parameter int REFRESH_DIV   = 50000,
    parameter int ACTIVE_LOW_AN = 1
) (
    input  logic              clk,
    input  logic              reset,
    seven_seg_scan_if.slave   sif
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);

    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0]      LAST_PRE = PRE_W'(REFRESH_DIV - 1);
    // Anode pattern with every digit switched off, in the configured polarity.
    localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ACTIVE_LOW_AN != 0}};
    localparam logic [6:0]            SEG_DARK = 7'b1111111;

    // Scan state
    logic [PRE_W-1:0]        presc_q, presc_d;
    logic [IDX_W-1:0]        idx_q, idx_d;

    // Shadow registers
    logic [4*NUM_DIGITS-1:0] data_q, data_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   dpm_q, dpm_d;

    // Registered display outputs
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    // Per-digit leading-zero flags derived from the shadow data
    logic [NUM_DIGITS-1:0]   lead_zero;

    // Selected-digit attributes
    logic [3:0]              sel_nib;
    logic                    sel_blank;
    logic                    sel_lz;
    logic                    sel_dp;
    logic [NUM_DIGITS-1:0]   sel_onehot;
    logic                    dark;

    function automatic logic [6:0] glyph(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1011000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0011000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // A digit is a leading zero when it and every digit above it are zero.
    // The chain runs from the top digit down; digit 0 is always displayed.
    // Each stage keeps its flag in its own generate scope so the chain is
    // not a self-dependent vector.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            logic lz;
            if (gi == 0) begin : g_first
                assign lz = 1'b0;
            end else if (gi == NUM_DIGITS - 1) begin : g_top
                assign lz = (data_q[4*gi +: 4] == 4'h0);
            end else begin : g_mid
                assign lz = (data_q[4*gi +: 4] == 4'h0) & g_digit[gi+1].lz;
            end
            assign lead_zero[gi] = lz;
        end
    endgenerate

    // Mux out the attributes of the digit currently scanned.
    always_comb begin
        sel_nib    = 4'h0;
        sel_blank  = 1'b0;
        sel_lz     = 1'b0;
        sel_dp     = 1'b0;
        sel_onehot = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                sel_nib       = data_q[4*i +: 4];
                sel_blank     = blank_q[i];
                sel_lz        = lead_zero[i];
                sel_dp        = dpm_q[i];
                sel_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        idx_d   = idx_q;
        data_d  = data_q;
        blank_d = blank_q;
        dpm_d   = dpm_q;

        if (presc_q == LAST_PRE) begin
            presc_d = '0;
            idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        end

        if (sif.load) begin
            data_d  = sif.dataIn;
            blank_d = sif.blankMask;
            dpm_d   = sif.dpIn;
        end

        // Leading-zero blanking darkens segments only; the decimal point
        // is suppressed solely by the blank mask.
        dark  = sel_blank | (sif.lzbEn & sel_lz);
        seg_d = dark ? SEG_DARK : glyph(sel_nib);
        dp_d  = ~(sel_dp & ~sel_blank);

        // XOR with the off pattern yields the one-hot enable in either polarity.
        an_d  = (presc_q == '0) ? AN_OFF : (AN_OFF ^ sel_onehot);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            blank_q <= '1;
            dpm_q   <= '0;
            seg_q   <= SEG_DARK;
            dp_q    <= 1'b1;
            an_q    <= AN_OFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            blank_q <= blank_d;
            dpm_q   <= dpm_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
            an_q    <= an_d;
        end
    end

    assign sif.sevenSegs = seg_q;
    assign sif.dp        = dp_q;
    assign sif.anodes    = an_q;
    assign sif.digitIdx  = idx_q;

endmodule

// File: tb/tb_seven_seg_scan.sv
// ---------------------------------------------------------------------------
// tb_seven_seg_scan
// Directed bench for seven_seg_scan with NUM_DIGITS=4, REFRESH_DIV=4,
// ACTIVE_LOW_AN=1. Every digit slot is stepped cycle by cycle and compared
// against hand-derived glyphs, decimal point, anodes and digit index.
// New shadow contents are loaded on the prescaler-wrap edge at the end of
// a slot, so the following slot must already show the new data.
// ---------------------------------------------------------------------------
module tb_seven_seg_scan;

    logic clk = 1'b0;
    logic reset;

    seven_seg_scan_if #(.NUM_DIGITS(4)) sif ();

    seven_seg_scan #(
        .NUM_DIGITS   (4),
        .REFRESH_DIV  (4),
        .ACTIVE_LOW_AN(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .sif  (sif)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Load scheduled for the wrap edge at the end of the next slot
    logic        pend_load;
    logic [15:0] pend_data;
    logic [3:0]  pend_blank;
    logic [3:0]  pend_dp;
    logic        pend_lzb;

    localparam logic [6:0] G_0    = 7'b1000000;
    localparam logic [6:0] G_1    = 7'b1111001;
    localparam logic [6:0] G_2    = 7'b0100100;
    localparam logic [6:0] G_3    = 7'b0110000;
    localparam logic [6:0] G_4    = 7'b0011001;
    localparam logic [6:0] G_A    = 7'b0001000;
    localparam logic [6:0] G_DARK = 7'b1111111;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string tag);
        check_val({tag, " seg"}, 32'(sif.sevenSegs), 32'(G_DARK));
        check_val({tag, " dp"},  32'(sif.dp),        32'd1);
        check_val({tag, " an"},  32'(sif.anodes),    32'hF);
        check_val({tag, " idx"}, 32'(sif.digitIdx),  32'd0);
        $display("reset check %s: seg=%b dp=%b an=%b idx=%0d",
                 tag, sif.sevenSegs, sif.dp, sif.anodes, sif.digitIdx);
    endtask

    task automatic schedule(input logic [15:0] data, input logic [3:0] bm,
                            input logic [3:0] dpv, input logic lzb);
        pend_load  = 1'b1;
        pend_data  = data;
        pend_blank = bm;
        pend_dp    = dpv;
        pend_lzb   = lzb;
    endtask

    // One full 4-cycle slot of digit d: the first output cycle has all
    // anodes off, the next three enable only digit d.
    task automatic slot(input int d, input logic [6:0] seg, input logic dpv);
        logic [3:0] an_exp;
        for (int t = 0; t < 4; t++) begin
            if (t == 3 && pend_load) begin
                sif.load      = 1'b1;
                sif.dataIn    = pend_data;
                sif.blankMask = pend_blank;
                sif.dpIn      = pend_dp;
                sif.lzbEn     = pend_lzb;
            end
            tick();
            sif.load = 1'b0;
            if (t == 3) pend_load = 1'b0;
            an_exp = (t == 0) ? 4'b1111 : ~(4'b0001 << d);
            check_val($sformatf("d%0d t%0d seg", d, t), 32'(sif.sevenSegs), 32'(seg));
            check_val($sformatf("d%0d t%0d dp", d, t),  32'(sif.dp),        32'(dpv));
            check_val($sformatf("d%0d t%0d an", d, t),  32'(sif.anodes),    32'(an_exp));
            if (t < 3)
                check_val($sformatf("d%0d t%0d idx", d, t), 32'(sif.digitIdx), d);
        end
        $display("slot digit %0d: seg=%b dp=%b an=%b", d, sif.sevenSegs, sif.dp, sif.anodes);
    endtask

    initial begin
        // Reset with a simultaneous load: reset must win.
        reset         = 1'b1;
        sif.load      = 1'b1;
        sif.dataIn    = 16'h1234;
        sif.blankMask = 4'b0000;
        sif.dpIn      = 4'b0000;
        sif.lzbEn     = 1'b0;
        pend_load     = 1'b0;
        pend_data     = '0;
        pend_blank    = '0;
        pend_dp       = '0;
        pend_lzb      = 1'b0;
        tick();
        check_reset_state("reset+load");
        reset    = 1'b0;
        sif.load = 1'b0;

        // Shadow is still at reset values (all blanked) for the first slot.
        schedule(16'h1234, 4'b0000, 4'b0000, 1'b0);
        slot(0, G_DARK, 1'b1);

        // 0x1234: two full 16-cycle rounds
        slot(1, G_3, 1'b1);
        slot(2, G_2, 1'b1);
        slot(3, G_1, 1'b1);
        slot(0, G_4, 1'b1);
        slot(1, G_3, 1'b1);
        slot(2, G_2, 1'b1);
        schedule(16'h00A0, 4'b0000, 4'b0000, 1'b1);
        slot(3, G_1, 1'b1);

        // 0x00A0 with leading-zero blanking
        slot(0, G_0, 1'b1);
        slot(1, G_A, 1'b1);
        slot(2, G_DARK, 1'b1);
        schedule(16'h0000, 4'b0000, 4'b0100, 1'b1);
        slot(3, G_DARK, 1'b1);

        // 0x0000, lzb on, dp on digit 2 survives leading-zero blanking
        slot(0, G_0, 1'b1);
        slot(1, G_DARK, 1'b1);
        slot(2, G_DARK, 1'b0);
        schedule(16'h1234, 4'b1111, 4'b1111, 1'b1);
        slot(3, G_DARK, 1'b1);

        // Blank mask hides segments and decimal points
        slot(0, G_DARK, 1'b1);
        slot(1, G_DARK, 1'b1);
        slot(2, G_DARK, 1'b1);
        schedule(16'h1234, 4'b0000, 4'b0000, 1'b0);
        slot(3, G_DARK, 1'b1);

        slot(0, G_4, 1'b1);
        slot(1, G_3, 1'b1);

        // Advance into digit 2 up to prescaler 2, then reset mid-slot.
        tick();
        check_val("pre-rst t0 seg", 32'(sif.sevenSegs), 32'(G_2));
        check_val("pre-rst t0 an",  32'(sif.anodes),    32'hF);
        check_val("pre-rst t0 idx", 32'(sif.digitIdx),  32'd2);
        tick();
        check_val("pre-rst t1 seg", 32'(sif.sevenSegs), 32'(G_2));
        check_val("pre-rst t1 an",  32'(sif.anodes),    32'b1011);
        check_val("pre-rst t1 idx", 32'(sif.digitIdx),  32'd2);
        reset = 1'b1;
        tick();
        check_reset_state("mid-slot reset");
        reset = 1'b0;

        // Scanning restarts at digit 0 with a full 4-cycle slot.
        schedule(16'h1234, 4'b0000, 4'b0000, 1'b0);
        slot(0, G_DARK, 1'b1);
        slot(1, G_3, 1'b1);
        slot(2, G_2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
